ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, driven by the ID/EX pipeline register outputs.
- Accepts one M-extension op from ID/EX, computes over a fixed number of cycles, then returns a registered result with its destination register.
- Drives stall_o back to ID/EX (and upstream) so the instruction is held in ID/EX while it executes.

Parameters:
XLEN, 32, operand/result width; the cycle counter is sized clog2(XLEN)+1.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-high reset
req_i  input  1  ID/EX holds a valid M-op (RegWrite & M-decode from ID/EX)
funct_i  input  10  {funct7,funct3} from ID/EX; M-op only when funct_i[9:3]==7'b0000001
RS1data_i  input  XLEN  operand A (forwarded)
RS2data_i  input  XLEN  operand B (forwarded)
RDaddr_i  input  5  destination register from ID/EX
kill_i  input  1  flush; aborts any in-flight op
stall_o  output  1  hold ID/EX and earlier stages
done_o  output  1  result_o/RDaddr_o valid, exactly one cycle
result_o  output  XLEN  result
RDaddr_o  output  5  destination register of the result

Behaviour:
- Reset (async, rst_i high):
  - state=IDLE; stall_o=0, done_o=0, result_o=0, RDaddr_o=0; counter and internal registers cleared.
  - Reset mid-operation discards the op; no done_o pulse is produced.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when req_i=1 and funct_i[9:3]==7'b0000001 and kill_i=0. Operands, funct3 and RDaddr_i are latched, count=0.
  - If req_i=1 but funct7 is not 0000001, the request is ignored and the unit stays IDLE.
  - BUSY: one iteration per cycle for XLEN cycles (count 0..XLEN-1). On the last iteration go to DONE and register result_o, RDaddr_o.
  - DONE: done_o=1 for exactly one cycle, then IDLE unconditionally. The req_i still asserted in DONE belongs to the same instruction and must not be re-accepted.
  - kill_i=1 in BUSY or DONE -> IDLE next edge with done_o=0. kill_i has priority over accept and completion.
- stall_o is combinational: (IDLE & accepting) | BUSY. It is 0 in DONE, so ID/EX advances on the DONE edge.
- Latency: accept edge E0; done_o high in the cycle after edge E(XLEN), i.e. XLEN+1 cycles after accept. Latency is fixed for every op, including special cases. Back-to-back ops lose no cycle beyond DONE.
- funct3 decode:
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH: high bits, signed x signed.
  - 010 MULHSU: high bits, signed x unsigned.
  - 011 MULHU: high bits, unsigned x unsigned.
  - 100 DIV, 101 DIVU: quotient.
  - 110 REM, 111 REMU: remainder.
- Multiply: shift-add on operand magnitudes into a 2*XLEN accumulator; the sign is applied at completion per op signedness.
- Divide: restoring division on magnitudes. Quotient sign = sA^sB; remainder takes the dividend's sign.
- Special cases, applied at completion:
  - Divisor 0: DIV/DIVU give all ones (0xFFFFFFFF); REM/REMU give A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Operand inputs are ignored after accept; changes on RS*data_i during BUSY have no effect.

Test Plan:
- MUL A=7, B=-3 (0xFFFFFFFD) -> stall_o high for 33 cycles (accept cycle + 32 BUSY); done_o one cycle later; result_o=0xFFFFFFEB, RDaddr_o as issued.
- MULH A=0x80000000, B=0x80000000 -> 0x40000000. MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU A=-1, B=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV A=-20, B=6 -> 0xFFFFFFFD (-3). REM A=-20, B=6 -> 0xFFFFFFFE (-2). DIVU A=20, B=6 -> 3. REMU A=20, B=6 -> 2.
- Special cases:
  - DIV A=5, B=0 -> 0xFFFFFFFF; REMU A=5, B=0 -> 5.
  - DIV A=0x80000000, B=-1 -> 0x80000000; REM same operands -> 0.
  - Each completes at the same fixed latency as a normal op.
- Back-to-back MUL then DIV with req_i held high -> exactly two done_o pulses, no re-accept in DONE. Non-M funct7 (0000000) with req_i=1 -> no stall, no done_o.
- kill_i at BUSY count=10, and separately rst_i at count=20 -> IDLE, stall_o=0, no done_o. A following MUL 3x4 -> result_o=12.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Accepts one M-op from ID/EX, iterates one bit per cycle for XLEN cycles, and then presents
// a registered result with its destination register for exactly one cycle (done_o).
module ex_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] RS1data_i,
    input  logic [XLEN-1:0] RS2data_i,
    input  logic [4:0]      RDaddr_i,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      RDaddr_o
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     count_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic [XLEN-1:0]     a_raw_q;
    logic [2:0]          funct3_q;
    logic [4:0]          rd_q;
    logic                sa_q, sb_q, b_zero_q;
    logic [XLEN-1:0]     result_q;
    logic [4:0]          rd_out_q;

    logic                accept, last_iter;
    logic [2:0]          f3_in;
    logic                sa_in, sb_in;
    logic [XLEN-1:0]     a_mag_in, b_mag_in;
    logic [XLEN:0]       mul_sum, div_r, div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   acc_n, prod;
    logic [XLEN-1:0]     quo, rem, quo_s, rem_s, result_n;

    assign f3_in     = funct_i[2:0];
    assign accept    = (state_q == StIdle) && req_i && (funct_i[9:3] == 7'b0000001) && !kill_i;
    assign last_iter = (state_q == StBusy) && (count_q == CntW'(XLEN - 1));

    // Operand signedness and magnitudes of the incoming request
    always_comb begin
        sa_in    = ((f3_in == 3'b001) || (f3_in == 3'b010) || (f3_in == 3'b100) ||
                    (f3_in == 3'b110)) && RS1data_i[XLEN-1];
        sb_in    = ((f3_in == 3'b001) || (f3_in == 3'b100) || (f3_in == 3'b110)) &&
                   RS2data_i[XLEN-1];
        a_mag_in = sa_in ? -RS1data_i : RS1data_i;
        b_mag_in = sb_in ? -RS2data_i : RS2data_i;
    end

    // One iteration: shift-add multiply step or restoring divide step on magnitudes
    always_comb begin
        // Multiply: multiplier sits in acc low half, partial product builds in the high half
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & a_q};
        // Divide: remainder in the high half, dividend shifts out / quotient shifts in below
        div_r    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_r - {1'b0, b_q};
        div_ge   = ~div_diff[XLEN];
        if (funct3_q[2]) begin
            acc_n = {(div_ge ? div_diff[XLEN-1:0] : div_r[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        end else begin
            acc_n = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Final sign fix-up and special cases, evaluated on the last iteration's value
    always_comb begin
        prod     = (sa_q ^ sb_q) ? -acc_n : acc_n;
        quo      = acc_n[XLEN-1:0];
        rem      = acc_n[2*XLEN-1:XLEN];
        quo_s    = (sa_q ^ sb_q) ? -quo : quo;
        rem_s    = sa_q ? -rem : rem;
        result_n = '0;
        unique case (funct3_q)
            3'b000:                 result_n = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_n = prod[2*XLEN-1:XLEN];
            3'b100:                 result_n = b_zero_q ? '1 : quo_s;
            3'b101:                 result_n = b_zero_q ? '1 : quo;
            3'b110:                 result_n = b_zero_q ? a_raw_q : rem_s;
            3'b111:                 result_n = b_zero_q ? a_raw_q : rem;
            default:                result_n = '0;
        endcase
    end

    // FSM next state and handshake outputs; kill wins over accept and completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StBusy;
            StBusy: begin
                if (kill_i) begin
                    state_d = StIdle;
                end else if (last_iter) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        stall_o = accept || (state_q == StBusy);
        done_o  = (state_q == StDone) && !kill_i;
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            a_raw_q  <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            b_zero_q <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (accept) begin
            count_q  <= '0;
            acc_q    <= {{XLEN{1'b0}}, (f3_in[2] ? a_mag_in : b_mag_in)};
            a_q      <= a_mag_in;
            b_q      <= b_mag_in;
            a_raw_q  <= RS1data_i;
            funct3_q <= f3_in;
            rd_q     <= RDaddr_i;
            sa_q     <= sa_in;
            sb_q     <= sb_in;
            b_zero_q <= (RS2data_i == '0);
        end else if (state_q == StBusy) begin
            acc_q   <= acc_n;
            count_q <= count_q + CntW'(1);
            if (last_iter && !kill_i) begin
                result_q <= result_n;
                rd_out_q <= rd_q;
            end
        end
    end

    assign result_o = result_q;
    assign RDaddr_o = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed and random M-ops against an arithmetic model.
module tb_ex_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [9:0]  funct_i;
    logic [31:0] RS1data_i, RS2data_i;
    logic [4:0]  RDaddr_i;
    logic        kill_i;
    logic        stall_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  RDaddr_o;

    int vectors = 0;
    int miscompares = 0;
    int done_pulses = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .funct_i   (funct_i),
        .RS1data_i (RS1data_i),
        .RS2data_i (RS2data_i),
        .RDaddr_i  (RDaddr_i),
        .kill_i    (kill_i),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .RDaddr_o  (RDaddr_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (done_o) done_pulses <= done_pulses + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // RV32M results straight from the ISA rules
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one M-op at the next falling edge and follow it to its done cycle.
    // Returns 1 ns into the done cycle with req_i still asserted.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input bit scramble);
        int cyc, stalls;
        bit seen;
        logic [31:0] exp;
        exp = ref_model(f3, a, b);
        @(negedge clk_i);
        req_i     = 1'b1;
        funct_i   = {7'b0000001, f3};
        RS1data_i = a;
        RS2data_i = b;
        RDaddr_i  = r;
        cyc = 0; stalls = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            #1;
            if (done_o) begin
                seen = 1'b1;
            end else begin
                stalls += int'(stall_o);
                @(negedge clk_i);
                cyc++;
                if (scramble) begin
                    RS1data_i = $urandom;
                    RS2data_i = $urandom;
                end
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(cyc), 32'd33);
        check("stall_cycles", 32'(stalls), 32'd33);
        check("stall_in_done", 32'(stall_o), 32'd0);
        check("result", result_o, exp);
        check("rd", 32'(RDaddr_o), 32'(r));
    endtask

    // Drop the request after done and confirm the pulse lasted one cycle
    task automatic release_op();
        req_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("done_one_cycle", 32'(done_o), 32'd0);
    endtask

    // Start a MUL and abort it via kill_i or rst_i while BUSY at the given count
    task automatic abort_op(input bit use_rst, input int at_count);
        int pulses0;
        @(negedge clk_i);
        req_i     = 1'b1;
        funct_i   = {7'b0000001, 3'b000};
        RS1data_i = $urandom;
        RS2data_i = $urandom;
        RDaddr_i  = 5'd9;
        pulses0   = done_pulses;
        repeat (at_count + 1) @(negedge clk_i);
        #1;
        check("busy_before_abort", 32'(stall_o), 32'd1);
        req_i = 1'b0;
        if (use_rst) begin
            rst_i = 1'b1;
            #1;
            check("rst_stall", 32'(stall_o), 32'd0);
            check("rst_done", 32'(done_o), 32'd0);
            check("rst_result", result_o, 32'd0);
            check("rst_rd", 32'(RDaddr_o), 32'd0);
            @(negedge clk_i);
            rst_i = 1'b0;
        end else begin
            kill_i = 1'b1;
            @(negedge clk_i);
            kill_i = 1'b0;
            #1;
            check("kill_stall", 32'(stall_o), 32'd0);
        end
        repeat (40) @(negedge clk_i);
        check("abort_no_done", 32'(done_pulses - pulses0), 32'd0);
        check("abort_idle_stall", 32'(stall_o), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int pulses0;
        rst_i = 1'b1; req_i = 1'b0; kill_i = 1'b0; funct_i = '0;
        RS1data_i = '0; RS2data_i = '0; RDaddr_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        check("reset_stall", 32'(stall_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        check("reset_rd", 32'(RDaddr_o), 32'd0);
        rst_i = 1'b0;

        // Directed arithmetic cases
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);  release_op();
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b1);  release_op();
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b0);  release_op();
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1);  release_op();
        run_op(3'b100, -32'sd20, 32'd6, 5'd10, 1'b1);  release_op();
        run_op(3'b110, -32'sd20, 32'd6, 5'd11, 1'b1);  release_op();
        run_op(3'b101, 32'd20, 32'd6, 5'd12, 1'b1);  release_op();
        run_op(3'b111, 32'd20, 32'd6, 5'd13, 1'b1);  release_op();
        // Divide-by-zero and signed overflow, same fixed latency
        run_op(3'b100, 32'd5, 32'd0, 5'd14, 1'b1);  release_op();
        run_op(3'b111, 32'd5, 32'd0, 5'd15, 1'b1);  release_op();
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1);  release_op();
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1'b1);  release_op();
        run_op(3'b110, -32'sd7, 32'd0, 5'd18, 1'b1);  release_op();

        // Back-to-back with req_i held through DONE
        pulses0 = done_pulses;
        run_op(3'b000, 32'd1234, 32'd5678, 5'd20, 1'b0);
        run_op(3'b100, 32'd1000, -32'sd7, 5'd21, 1'b0);
        release_op();
        repeat (5) @(negedge clk_i);
        check("b2b_two_pulses", 32'(done_pulses - pulses0), 32'd2);

        // Non-M funct7 is ignored
        @(negedge clk_i);
        pulses0   = done_pulses;
        req_i     = 1'b1;
        funct_i   = {7'b0000000, 3'b000};
        RS1data_i = 32'd5;
        RS2data_i = 32'd6;
        #1;
        check("nonm_stall", 32'(stall_o), 32'd0);
        repeat (40) @(negedge clk_i);
        check("nonm_no_done", 32'(done_pulses - pulses0), 32'd0);
        check("nonm_idle_stall", 32'(stall_o), 32'd0);
        req_i = 1'b0;

        // Kill with a pending request in IDLE suppresses acceptance
        @(negedge clk_i);
        req_i   = 1'b1;
        funct_i = {7'b0000001, 3'b000};
        kill_i  = 1'b1;
        #1;
        check("kill_blocks_accept", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        req_i  = 1'b0;
        kill_i = 1'b0;
        #1;
        check("kill_idle_stays", 32'(stall_o), 32'd0);

        // Aborts mid-operation, then a clean op
        abort_op(1'b0, 10);
        abort_op(1'b1, 20);
        run_op(3'b000, 32'd3, 32'd4, 5'd3, 1'b1);  release_op();

        // Random ops against the model
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   5'($urandom_range(0, 31)), 1'b1);
            release_op();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
